// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache port arbiter and its requesters.
package cache_pkg;

    localparam int CACHE_ADDR_W = 32;
    localparam int CACHE_DATA_W = 32;
    localparam int CACHE_STRB_W = CACHE_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Request fields carried at the package-default widths.
    typedef struct packed {
        logic                    rw;
        logic [CACHE_ADDR_W-1:0] addr;
        logic [CACHE_DATA_W-1:0] wdata;
        logic [CACHE_STRB_W-1:0] wstrb;
    } cpu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin select: a lone requester always wins, a tie goes to ptr.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Serialises two requesters onto one blocking cache port, one transaction at a time.
//   state    | meaning
//   IDLE     | accept a request from the round-robin winner
//   ISSUE    | present latched request downstream until accepted
//   WAIT     | count cycles until response or timeout
//   RESP     | one-cycle response pulse to the granted requester
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W      = CACHE_ADDR_W,
    parameter int DATA_W      = CACHE_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req_valid,
    input  logic                m0_req_rw,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_req_ready,
    output logic                m0_resp_valid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req_valid,
    input  logic                m1_req_rw,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_req_ready,
    output logic                m1_resp_valid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                cpu_req_valid,
    output logic                cpu_req_rw,
    output logic [ADDR_W-1:0]   cpu_addr,
    output logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W/8-1:0] cpu_wstrb,
    input  logic                cpu_req_ready,
    input  logic                cpu_resp_valid,
    input  logic [DATA_W-1:0]   cpu_rdata,

    output logic                timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t       state;
    logic             rr_ptr;
    logic             owner;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       grant;
    cpu_req_t         req_q;
    cpu_req_t         win_req;

    rr_arb2 u_rr_arb2 (
        .req   ({m1_req_valid, m0_req_valid}),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        win_req.rw    = m0_req_rw;
        win_req.addr  = CACHE_ADDR_W'(m0_addr);
        win_req.wdata = CACHE_DATA_W'(m0_wdata);
        win_req.wstrb = CACHE_STRB_W'(m0_wstrb);
        if (grant[1]) begin
            win_req.rw    = m1_req_rw;
            win_req.addr  = CACHE_ADDR_W'(m1_addr);
            win_req.wdata = CACHE_DATA_W'(m1_wdata);
            win_req.wstrb = CACHE_STRB_W'(m1_wstrb);
        end
    end

    // Ready is gated by rst_n so a held request cannot look accepted while in reset.
    assign m0_req_ready  = rst_n && (state == ST_IDLE) && grant[0];
    assign m1_req_ready  = rst_n && (state == ST_IDLE) && grant[1];
    assign m0_resp_valid = (state == ST_RESP) && !owner;
    assign m1_resp_valid = (state == ST_RESP) && owner;

    assign cpu_req_valid = (state == ST_ISSUE);
    assign cpu_req_rw    = req_q.rw;
    assign cpu_addr      = ADDR_W'(req_q.addr);
    assign cpu_wdata     = DATA_W'(req_q.wdata);
    assign cpu_wstrb     = (DATA_W/8)'(req_q.wstrb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            req_q       <= '0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner  <= grant[1];
                        rr_ptr <= grant[0];
                        req_q  <= win_req;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cpu_req_ready) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response on the expiry cycle wins over the timeout.
                    if (cpu_resp_valid) begin
                        if (owner) m1_rdata <= cpu_rdata;
                        else       m0_rdata <= cpu_rdata;
                        state <= ST_RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        if (owner) m1_rdata <= '0;
                        else       m0_rdata <= '0;
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
